// File: rtl/binop_sequencer.sv
// binop_sequencer
// Executes one WebAssembly binary numeric instruction (i32/i64 arithmetic and
// comparison) against the operand stack using the shared ALU: pops the right
// operand, then the left operand, issues one ALU operation, waits for the
// result and pushes it back.  Stack underflow, illegal opcodes and ALU traps
// end in a sticky TRAP state that only reset leaves.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   op_valid/op_code      opcode offered by the decoder
//   op_ready              sequencer idle and able to accept
//   busy                  high in every state except IDLE and TRAP
//   stack_count/top       stack occupancy and combinational top-of-stack
//   stack_pop/push/wdata  stack strobes and value to push
//   alu_start/op/a/b      ALU issue strobe, opcode and operands
//   alu_done/result/trap  ALU completion, result and trap code
//   trap                  sticky trap code (0 none, 2 underflow, 3 illegal,
//                         otherwise the ALU trap code)
module binop_sequencer #(
  parameter int WIDTH   = 64,
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [7:0]         op_code,
  output logic               op_ready,
  output logic               busy,
  input  logic [DEPTH_W-1:0] stack_count,
  input  logic [WIDTH-1:0]   stack_top,
  output logic               stack_pop,
  output logic               stack_push,
  output logic [WIDTH-1:0]   stack_wdata,
  output logic               alu_start,
  output logic [7:0]         alu_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic               alu_done,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic [3:0]         alu_trap,
  output logic [3:0]         trap
);

  typedef enum logic [2:0] {
    S_IDLE, S_POP_B, S_POP_A, S_ISSUE, S_WAIT, S_PUSH, S_TRAP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       trap_nxt;
  logic [7:0]       op_q;
  logic             is_i32_q;
  logic [WIDTH-1:0] b_q;

  // Binary i32/i64 arithmetic and comparison opcodes; unary and conversion
  // opcodes in between are rejected.
  function automatic logic op_legal(input logic [7:0] op);
    return (op >= 8'h46 && op <= 8'h4F) || (op >= 8'h51 && op <= 8'h5A) ||
           (op >= 8'h6A && op <= 8'h78) || (op >= 8'h7C && op <= 8'h8A);
  endfunction

  function automatic logic op_is_i32(input logic [7:0] op);
    return (op >= 8'h46 && op <= 8'h4F) || (op >= 8'h6A && op <= 8'h78);
  endfunction

  // i32 operations see and produce only the low word, upper word zeroed.
  function automatic logic [WIDTH-1:0] narrow(input logic [WIDTH-1:0] v,
                                              input logic is32);
    return is32 ? {{(WIDTH-32){1'b0}}, v[31:0]} : v;
  endfunction

  always_comb begin
    state_nxt = state;
    trap_nxt  = trap;
    case (state)
      S_IDLE: begin
        if (op_valid) begin
          if (!op_legal(op_code)) begin
            trap_nxt  = 4'd3;
            state_nxt = S_TRAP;
          end else if (stack_count < DEPTH_W'(2)) begin
            trap_nxt  = 4'd2;
            state_nxt = S_TRAP;
          end else begin
            state_nxt = S_POP_B;
          end
        end
      end
      S_POP_B: state_nxt = S_POP_A;
      S_POP_A: state_nxt = S_ISSUE;
      // alu_done is deliberately not looked at until the first WAIT cycle.
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (alu_done) begin
          if (alu_trap != 4'd0) begin
            trap_nxt  = alu_trap;
            state_nxt = S_TRAP;
          end else begin
            state_nxt = S_PUSH;
          end
        end
      end
      S_PUSH:  state_nxt = S_IDLE;
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Every output is a flop decoded from the next state, so strobes line up
  // with the state they belong to without combinational output paths.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      trap        <= 4'd0;
      op_ready    <= 1'b1;
      busy        <= 1'b0;
      stack_pop   <= 1'b0;
      stack_push  <= 1'b0;
      alu_start   <= 1'b0;
      alu_op      <= 8'd0;
      alu_a       <= '0;
      alu_b       <= '0;
      stack_wdata <= '0;
      op_q        <= 8'd0;
      is_i32_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      trap       <= trap_nxt;
      op_ready   <= (state_nxt == S_IDLE);
      busy       <= (state_nxt != S_IDLE) && (state_nxt != S_TRAP);
      stack_pop  <= (state_nxt == S_POP_B) || (state_nxt == S_POP_A);
      stack_push <= (state_nxt == S_PUSH);
      alu_start  <= (state_nxt == S_ISSUE);
      if (state == S_IDLE && op_valid) begin
        op_q     <= op_code;
        is_i32_q <= op_is_i32(op_code);
      end
      // The left operand goes straight from the stack into alu_a; the ALU
      // operands then hold until the next instruction reaches ISSUE.
      if (state == S_POP_A) begin
        alu_a  <= narrow(stack_top, is_i32_q);
        alu_b  <= narrow(b_q, is_i32_q);
        alu_op <= op_q;
      end
      if (state == S_WAIT && alu_done && alu_trap == 4'd0)
        stack_wdata <= narrow(alu_result, is_i32_q);
    end
  end

  // Right operand holding register; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (state == S_POP_B)
      b_q <= stack_top;
  end

endmodule

// File: tb/tb_binop_sequencer.sv
// Testbench for binop_sequencer: models the operand stack and a simple ALU,
// predicts each instruction's outcome from the opcode-class rules and checks
// pops, operands, pushes, traps and latency.
module tb_binop_sequencer;
  localparam int WIDTH   = 64;
  localparam int DEPTH_W = 8;

  logic               clk;
  logic               reset;
  logic               op_valid;
  logic [7:0]         op_code;
  logic               op_ready;
  logic               busy;
  logic [DEPTH_W-1:0] stack_count;
  logic [WIDTH-1:0]   stack_top;
  logic               stack_pop;
  logic               stack_push;
  logic [WIDTH-1:0]   stack_wdata;
  logic               alu_start;
  logic [7:0]         alu_op;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic               alu_done;
  logic [WIDTH-1:0]   alu_result;
  logic [3:0]         alu_trap;
  logic [3:0]         trap;

  binop_sequencer #(.WIDTH(WIDTH), .DEPTH_W(DEPTH_W)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .busy(busy), .stack_count(stack_count),
    .stack_top(stack_top), .stack_pop(stack_pop), .stack_push(stack_push),
    .stack_wdata(stack_wdata), .alu_start(alu_start), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done),
    .alu_result(alu_result), .alu_trap(alu_trap), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand stack model: mem[0] is the bottom, mem[sp-1] the top.
  logic [WIDTH-1:0] mem [0:15];
  int sp;
  assign stack_count = DEPTH_W'(sp);
  assign stack_top   = (sp > 0) ? mem[4'(sp - 1)] : '0;

  // ALU model configuration and state
  int          cfg_extra;
  logic [63:0] cfg_res;
  logic [3:0]  cfg_trap;
  bit          alu_busy;
  int          alu_wait;
  bit          in_flight;

  // Per-cycle samples and per-instruction observations
  logic        s_ready, s_busy, s_pop, s_push, s_start;
  logic [3:0]  s_trap;
  int          obs_pops, obs_pushes, obs_starts, obs_latency;
  logic [63:0] obs_a, obs_b, obs_push_val;
  logic [7:0]  obs_op;
  bit          obs_excl, obs_stable;
  logic [3:0]  obs_trap1, obs_trap;
  logic        obs_busy1, obs_busy_end, obs_ready_end, obs_ready0;
  logic [63:0] popped [$];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          pops;
    int          pushes;
    int          starts;
    int          latency;
    logic [3:0]  trap_early;
    logic [3:0]  trap;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] push_val;
  } exp_t;

  exp_t ex;

  // Reference model: outcome of one instruction from the opcode class rules.
  function automatic exp_t predict(input logic [7:0] op, input int cnt,
                                   input logic [63:0] top, input logic [63:0] second,
                                   input int extra, input logic [63:0] res,
                                   input logic [3:0] atrap);
    exp_t e;
    bit legal, n32;
    logic [63:0] m;
    legal = (op >= 8'h46 && op <= 8'h4F) || (op >= 8'h51 && op <= 8'h5A) ||
            (op >= 8'h6A && op <= 8'h78) || (op >= 8'h7C && op <= 8'h8A);
    n32   = (op >= 8'h46 && op <= 8'h4F) || (op >= 8'h6A && op <= 8'h78);
    m = n32 ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    e.pops = 0; e.pushes = 0; e.starts = 0; e.latency = -1;
    e.trap_early = 4'd0; e.trap = 4'd0; e.a = '0; e.b = '0; e.push_val = '0;
    if (!legal) begin
      e.trap = 4'd3; e.trap_early = 4'd3;
    end else if (cnt < 2) begin
      e.trap = 4'd2; e.trap_early = 4'd2;
    end else begin
      e.pops = 2; e.starts = 1;
      e.b = top & m; e.a = second & m;
      if (atrap != 4'd0) e.trap = atrap;
      else begin
        e.pushes = 1; e.push_val = res & m; e.latency = 6 + extra;
      end
    end
    return e;
  endfunction

  // One clock: sample outputs at the falling edge, then after the rising edge
  // apply the stack and ALU side effects the DUT requested in that cycle.
  task automatic step();
    @(negedge clk);
    s_ready = op_ready; s_busy = busy; s_trap = trap;
    s_pop = stack_pop; s_push = stack_push; s_start = alu_start;
    if (int'(stack_pop) + int'(stack_push) + int'(alu_start) > 1) obs_excl = 1'b1;
    if (alu_start) begin
      obs_starts++; obs_a = alu_a; obs_b = alu_b; obs_op = alu_op;
    end else if (in_flight && (alu_a !== obs_a || alu_b !== obs_b || alu_op !== obs_op)) begin
      obs_stable = 1'b1;
    end
    if (stack_push) begin
      obs_pushes++; obs_push_val = stack_wdata;
    end
    @(posedge clk);
    #1;
    if (s_pop) begin
      obs_pops++;
      if (sp > 0) begin sp--; popped.push_back(mem[4'(sp)]); end
    end
    if (s_push && sp < 16) begin
      mem[4'(sp)] = obs_push_val; sp++;
    end
    if (alu_done) begin
      alu_done = 1'b0; alu_result = '0; alu_trap = '0; in_flight = 1'b0;
    end else if (alu_busy) begin
      alu_wait--;
      if (alu_wait == 0) begin
        alu_done = 1'b1; alu_result = cfg_res; alu_trap = cfg_trap; alu_busy = 1'b0;
      end
    end
    if (s_start) begin
      in_flight = 1'b1;
      if (cfg_extra == 0) begin
        alu_done = 1'b1; alu_result = cfg_res; alu_trap = cfg_trap;
      end else begin
        alu_busy = 1'b1; alu_wait = cfg_extra;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; op_valid = 1'b0; op_code = 8'h00;
    alu_done = 1'b0; alu_result = '0; alu_trap = '0;
    alu_busy = 1'b0; in_flight = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load2(input logic [63:0] lower, input logic [63:0] upper);
    mem[0] = lower; mem[1] = upper; sp = 2;
  endtask

  // Offers one opcode, then clocks until op_ready returns or the budget runs
  // out (obs_latency stays -1).  With noise, an illegal opcode is offered
  // during busy cycles and must be ignored.
  task automatic run_op(input logic [7:0] op, input int extra, input logic [63:0] res,
                        input logic [3:0] atrap, input int budget, input bit noise);
    cfg_extra = extra; cfg_res = res; cfg_trap = atrap;
    obs_pops = 0; obs_pushes = 0; obs_starts = 0; obs_latency = -1;
    obs_excl = 1'b0; obs_stable = 1'b0; obs_push_val = '0;
    obs_a = '0; obs_b = '0; obs_op = '0;
    popped.delete();
    op_valid = 1'b1; op_code = op;
    step();
    obs_ready0 = s_ready;
    op_valid = 1'b0; op_code = 8'h00;
    for (int k = 1; k <= budget; k++) begin
      if (noise && k <= 4) begin op_valid = 1'b1; op_code = 8'h00; end
      else op_valid = 1'b0;
      step();
      if (k == 1) begin obs_trap1 = s_trap; obs_busy1 = s_busy; end
      if (s_ready) begin obs_latency = k; break; end
    end
    op_valid = 1'b0;
    obs_trap = s_trap; obs_busy_end = s_busy; obs_ready_end = s_ready;
  endtask

  task automatic exec(input logic [7:0] op, input int extra, input logic [63:0] res,
                      input logic [3:0] atrap, input bit noise);
    ex = predict(op, sp, (sp > 0) ? mem[4'(sp - 1)] : '0,
                 (sp > 1) ? mem[4'(sp - 2)] : '0, extra, res, atrap);
    run_op(op, extra, res, atrap, (ex.latency > 0) ? ex.latency + 6 : 12, noise);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    n_checks++; if (op_ready !== 1'b1) $display("FAIL reset_op_ready: got %b want 1", op_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if ({stack_pop, stack_push, alu_start} !== 3'b000)
      $display("FAIL reset_strobes: got %b want 000", {stack_pop, stack_push, alu_start}); else n_pass++;
    n_checks++; if ({alu_op, alu_a, alu_b, stack_wdata} !== '0)
      $display("FAIL reset_data: got op=%0h a=%0h b=%0h wdata=%0h want all 0", alu_op, alu_a, alu_b, stack_wdata); else n_pass++;
    n_checks++; if (trap !== 4'd0) $display("FAIL reset_trap: got %0d want 0", trap); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (op_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: got ready=%b busy=%b want 1/0", op_ready, busy); else n_pass++;
  endtask

  task automatic test_i32_ne();
    logic [63:0] p0, p1;
    load2(64'd2, 64'd3);
    exec(8'h47, 0, 64'd1, 4'd0, 1'b0);
    p0 = (popped.size() > 0) ? popped[0] : '1;
    p1 = (popped.size() > 1) ? popped[1] : '1;
    n_checks++; if (obs_ready0 !== 1'b1) $display("FAIL ne_ready_before: got %b want 1", obs_ready0); else n_pass++;
    n_checks++; if (p0 !== 64'd3 || p1 !== 64'd2) $display("FAIL ne_pop_order: got %0h,%0h want 3,2", p0, p1); else n_pass++;
    n_checks++; if (obs_a !== ex.a || obs_b !== ex.b) $display("FAIL ne_operands: got a=%0h b=%0h want a=%0h b=%0h", obs_a, obs_b, ex.a, ex.b); else n_pass++;
    n_checks++; if (obs_op !== 8'h47) $display("FAIL ne_alu_op: got %0h want 47", obs_op); else n_pass++;
    n_checks++; if (obs_busy1 !== 1'b1) $display("FAIL ne_busy: got %b want 1", obs_busy1); else n_pass++;
    n_checks++; if (obs_latency !== ex.latency) $display("FAIL ne_latency: got %0d want %0d", obs_latency, ex.latency); else n_pass++;
    n_checks++; if (sp !== 1 || mem[0] !== 64'd1 || obs_trap !== 4'd0)
      $display("FAIL ne_result: got sp=%0d top=%0h trap=%0d want 1/1/0", sp, mem[0], obs_trap); else n_pass++;
  endtask

  task automatic test_sub_wait();
    load2(64'd5, 64'd3);
    exec(8'h6B, 2, 64'd2, 4'd0, 1'b0);
    n_checks++; if (obs_starts !== 1) $display("FAIL sub_start_cycles: got %0d want 1", obs_starts); else n_pass++;
    n_checks++; if (obs_stable !== 1'b0) $display("FAIL sub_operand_hold: got changed=%b want 0", obs_stable); else n_pass++;
    n_checks++; if (obs_pushes !== 1 || obs_push_val !== 64'd2)
      $display("FAIL sub_push: got n=%0d val=%0h want 1/2", obs_pushes, obs_push_val); else n_pass++;
    n_checks++; if (obs_latency !== 8) $display("FAIL sub_latency: got %0d want 8", obs_latency); else n_pass++;
    n_checks++; if (obs_excl !== 1'b0) $display("FAIL sub_strobe_overlap: got %b want 0", obs_excl); else n_pass++;
  endtask

  task automatic test_width();
    load2(64'h1_FFFF_FFFF, 64'd1);
    exec(8'h6A, 0, 64'h1_0000_0000, 4'd0, 1'b0);
    n_checks++; if (obs_a !== 64'h0000_0000_FFFF_FFFF || obs_b !== 64'd1)
      $display("FAIL i32_operands: got a=%0h b=%0h want ffffffff/1", obs_a, obs_b); else n_pass++;
    n_checks++; if (obs_push_val !== 64'd0) $display("FAIL i32_result_zext: got %0h want 0", obs_push_val); else n_pass++;
    sp = 0;
    load2(64'h1_FFFF_FFFF, 64'h8000_0000_0000_0001);
    exec(8'h7C, 1, 64'h2_0000_0005, 4'd0, 1'b0);
    n_checks++; if (obs_a !== ex.a || obs_b !== ex.b)
      $display("FAIL i64_operands: got a=%0h b=%0h want %0h/%0h", obs_a, obs_b, ex.a, ex.b); else n_pass++;
    n_checks++; if (obs_push_val !== 64'h2_0000_0005) $display("FAIL i64_result: got %0h want 200000005", obs_push_val); else n_pass++;
  endtask

  task automatic test_underflow();
    sp = 0; mem[0] = 64'd9; sp = 1;
    exec(8'h7C, 0, 64'd0, 4'd0, 1'b0);
    n_checks++; if (obs_trap1 !== 4'd2) $display("FAIL underflow_trap: got %0d want 2", obs_trap1); else n_pass++;
    n_checks++; if (obs_pops !== 0 || obs_starts !== 0)
      $display("FAIL underflow_activity: got pops=%0d starts=%0d want 0/0", obs_pops, obs_starts); else n_pass++;
    n_checks++; if (obs_latency !== -1 || obs_ready_end !== 1'b0 || obs_busy_end !== 1'b0)
      $display("FAIL underflow_terminal: got lat=%0d ready=%b busy=%b want -1/0/0", obs_latency, obs_ready_end, obs_busy_end); else n_pass++;
    do_reset();
  endtask

  task automatic test_illegal_and_alu_trap();
    sp = 0; load2(64'd1, 64'd2);
    exec(8'h00, 0, 64'd0, 4'd0, 1'b0);
    n_checks++; if (obs_trap1 !== 4'd3) $display("FAIL illegal_trap: got %0d want 3", obs_trap1); else n_pass++;
    n_checks++; if (obs_pops !== 0 || obs_pushes !== 0 || sp !== 2)
      $display("FAIL illegal_activity: got pops=%0d pushes=%0d sp=%0d want 0/0/2", obs_pops, obs_pushes, sp); else n_pass++;
    do_reset();
    sp = 0; load2(64'd7, 64'd0);
    exec(8'h6D, 1, 64'd0, 4'd4, 1'b0);
    n_checks++; if (obs_trap !== 4'd4) $display("FAIL alu_trap_code: got %0d want 4", obs_trap); else n_pass++;
    n_checks++; if (obs_pops !== 2 || obs_pushes !== 0 || sp !== 0)
      $display("FAIL alu_trap_stack: got pops=%0d pushes=%0d sp=%0d want 2/0/0", obs_pops, obs_pushes, sp); else n_pass++;
    n_checks++; if (obs_ready_end !== 1'b0 || obs_busy_end !== 1'b0)
      $display("FAIL alu_trap_terminal: got ready=%b busy=%b want 0/0", obs_ready_end, obs_busy_end); else n_pass++;
    do_reset();
  endtask

  task automatic test_reset_mid();
    sp = 0; load2(64'd9, 64'd8);
    cfg_extra = 20; cfg_res = 64'd0; cfg_trap = 4'd0;
    op_valid = 1'b1; op_code = 8'h6A;
    step();
    op_valid = 1'b0; op_code = 8'h00;
    repeat (5) step();
    #2 reset = 1'b0;
    #1;
    n_checks++; if (op_ready !== 1'b1 || busy !== 1'b0 || trap !== 4'd0)
      $display("FAIL midreset_ctrl: got ready=%b busy=%b trap=%0d want 1/0/0", op_ready, busy, trap); else n_pass++;
    n_checks++; if ({stack_pop, stack_push, alu_start} !== 3'b000 || {alu_op, alu_a, alu_b, stack_wdata} !== '0)
      $display("FAIL midreset_outputs: got strobes=%b a=%0h b=%0h op=%0h want 0", {stack_pop, stack_push, alu_start}, alu_a, alu_b, alu_op); else n_pass++;
    n_checks++; if (sp !== 0) $display("FAIL midreset_pops_kept: got sp=%0d want 0", sp); else n_pass++;
    alu_done = 1'b0; alu_busy = 1'b0; in_flight = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    load2(64'd4, 64'd4);
    exec(8'h47, 0, 64'd0, 4'd0, 1'b0);
    n_checks++; if (obs_pushes !== 1 || obs_push_val !== 64'd0 || obs_latency !== 6)
      $display("FAIL midreset_after: got pushes=%0d val=%0h lat=%0d want 1/0/6", obs_pushes, obs_push_val, obs_latency); else n_pass++;
  endtask

  task automatic test_opcode_ranges();
    logic [7:0] ops [16];
    ops = '{8'h45, 8'h46, 8'h4F, 8'h50, 8'h51, 8'h5A, 8'h5B, 8'h69,
            8'h6A, 8'h78, 8'h79, 8'h7B, 8'h7C, 8'h8A, 8'h8B, 8'hFF};
    for (int i = 0; i < 16; i++) begin
      sp = 0;
      load2({$urandom, $urandom}, {$urandom, $urandom});
      exec(ops[i], 0, {$urandom, $urandom}, 4'd0, 1'b0);
      n_checks++; if (obs_trap1 !== ex.trap_early || obs_pops !== ex.pops)
        $display("FAIL range_%0h: got trap=%0d pops=%0d want %0d/%0d", ops[i], obs_trap1, obs_pops, ex.trap_early, ex.pops); else n_pass++;
      n_checks++; if (obs_push_val !== ex.push_val || obs_latency !== ex.latency)
        $display("FAIL range_%0h_result: got val=%0h lat=%0d want %0h/%0d", ops[i], obs_push_val, obs_latency, ex.push_val, ex.latency); else n_pass++;
      if (ex.trap != 4'd0) do_reset();
    end
  endtask

  task automatic test_back_to_back();
    sp = 0; mem[0] = 64'd10; mem[1] = 64'd20; mem[2] = 64'd30; sp = 3;
    exec(8'h7C, 0, 64'd50, 4'd0, 1'b1);
    n_checks++; if (obs_trap !== 4'd0 || obs_pushes !== 1 || obs_latency !== 6)
      $display("FAIL b2b_first: got trap=%0d pushes=%0d lat=%0d want 0/1/6", obs_trap, obs_pushes, obs_latency); else n_pass++;
    exec(8'h7D, 1, 64'd40, 4'd0, 1'b1);
    n_checks++; if (obs_a !== 64'd10 || obs_b !== 64'd50)
      $display("FAIL b2b_second_operands: got a=%0h b=%0h want a/32", obs_a, obs_b); else n_pass++;
    n_checks++; if (sp !== 1 || mem[0] !== 64'd40 || obs_trap !== 4'd0)
      $display("FAIL b2b_second_result: got sp=%0d top=%0h trap=%0d want 1/28/0", sp, mem[0], obs_trap); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] op;
    int depth, extra, sp0;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: op = 8'($urandom_range(8'h46, 8'h4F));
        1: op = 8'($urandom_range(8'h51, 8'h5A));
        2: op = 8'($urandom_range(8'h6A, 8'h78));
        default: op = 8'($urandom_range(8'h7C, 8'h8A));
      endcase
      depth = $urandom_range(2, 4);
      sp = 0;
      for (int d = 0; d < depth; d++) begin mem[4'(d)] = {$urandom, $urandom}; sp++; end
      sp0 = sp;
      extra = $urandom_range(0, 3);
      exec(op, extra, {$urandom, $urandom}, 4'd0, i[0]);
      n_checks++; if (obs_trap !== ex.trap) $display("FAIL rand%0d_trap: got %0d want %0d", i, obs_trap, ex.trap); else n_pass++;
      n_checks++; if (obs_a !== ex.a || obs_b !== ex.b || obs_op !== op)
        $display("FAIL rand%0d_operands: got a=%0h b=%0h op=%0h want %0h/%0h/%0h", i, obs_a, obs_b, obs_op, ex.a, ex.b, op); else n_pass++;
      n_checks++; if (obs_pops !== ex.pops || obs_pushes !== ex.pushes || obs_starts !== ex.starts)
        $display("FAIL rand%0d_counts: got %0d/%0d/%0d want %0d/%0d/%0d", i, obs_pops, obs_pushes, obs_starts, ex.pops, ex.pushes, ex.starts); else n_pass++;
      n_checks++; if (obs_push_val !== ex.push_val) $display("FAIL rand%0d_push: got %0h want %0h", i, obs_push_val, ex.push_val); else n_pass++;
      n_checks++; if (obs_latency !== ex.latency) $display("FAIL rand%0d_latency: got %0d want %0d", i, obs_latency, ex.latency); else n_pass++;
      n_checks++; if (obs_excl !== 1'b0 || obs_stable !== 1'b0)
        $display("FAIL rand%0d_strobes: got overlap=%b changed=%b want 0/0", i, obs_excl, obs_stable); else n_pass++;
      n_checks++; if (sp !== sp0 - 1 || mem[4'(sp0 - 2)] !== ex.push_val)
        $display("FAIL rand%0d_stack: got sp=%0d want %0d", i, sp, sp0 - 1); else n_pass++;
    end
  endtask

  initial begin
    op_valid = 1'b0; op_code = 8'h00;
    alu_done = 1'b0; alu_result = '0; alu_trap = '0;
    alu_busy = 1'b0; alu_wait = 0; in_flight = 1'b0;
    cfg_extra = 0; cfg_res = '0; cfg_trap = '0;
    sp = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_i32_ne();
    test_sub_wait();
    test_width();
    test_underflow();
    test_illegal_and_alu_trap();
    test_reset_mid();
    test_opcode_ranges();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish within 300000 time units");
    $fatal(1, "timeout");
  end

endmodule
